cb_serial_adder: RTL and testbench

Nibble-serial wide adder that streams a WIDTH-bit addition through a single 4-bit carry-bypass slice, one nibble per clock, carrying between cycles in a register. It sits as the sequencing stage around the team's 4-bit carry-bypass adder cell. It lets wide additions reuse one slice instead of a full-width ripple/bypass chain. Operands enter and results leave over valid/ready handshakes.

---
 rtl/cb_serial_adder.sv | 128 ++++++++++++
 tb/tb_cb_serial_adder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_serial_adder.sv
// Nibble-serial WIDTH-bit adder built around one 4-bit carry-bypass slice.
// Optional macro CBSA_BYPASS_STATS_EN adds the bypass_cnt statistics port.
module cb_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CBSA_BYPASS_STATS_EN
    ,
    output logic [$clog2(WIDTH/4+1)-1:0] bypass_cnt
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       a_nib, b_nib;
    logic [4:0]       slice_res;

    // 4-bit carry-bypass slice: ripple internally, but when every bit
    // propagates the carry-in is forwarded straight to the carry-out.
    function automatic logic [4:0] cb_slice(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci);
        logic [3:0] p, g, s;
        logic       c;
        p = x ^ y;
        g = x & y;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {(&p) ? ci : c, s};
    endfunction

    assign a_nib     = a_q[{idx, 2'b00} +: 4];
    assign b_nib     = b_q[{idx, 2'b00} +: 4];
    assign slice_res = cb_slice(a_nib, b_nib, carry);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement leaves a value unassigned (no latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == IW'(N - 1)) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    carry <= cin;
                    idx   <= '0;
                    sum_q <= '0;
                end
                RUN: begin
                    sum_q[{idx, 2'b00} +: 4] <= slice_res[3:0];
                    carry                    <= slice_res[4];
                    idx                      <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CBSA_BYPASS_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bypass_cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            bypass_cnt <= '0;
        end else if (state == RUN && (&(a_nib ^ b_nib))) begin
            bypass_cnt <= bypass_cnt + 1'b1;
        end
    end
`endif

    // The carry register doubles as cout: it holds the final carry from DONE
    // until the next acceptance reloads it with cin.
    assign sum  = sum_q;
    assign cout = carry;

endmodule

// File: tb/tb_cb_serial_adder.sv
// Self-checking bench for cb_serial_adder (WIDTH=16 and WIDTH=32 instances)
// against an arithmetic reference model.
module tb_cb_serial_adder;

    localparam int W  = 16;
    localparam int N  = W / 4;
    localparam int W2 = 32;
    localparam int N2 = W2 / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    logic          xin_valid, xin_ready, xcin, xout_valid, xout_ready, xcout, xbusy;
    logic [W2-1:0] xa, xb, xsum;
`ifdef CBSA_BYPASS_STATS_EN
    logic [$clog2(N+1)-1:0]  bypass_cnt;
    logic [$clog2(N2+1)-1:0] xbypass_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cb_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef CBSA_BYPASS_STATS_EN
        , .bypass_cnt(bypass_cnt)
`endif
    );

    cb_serial_adder #(.WIDTH(W2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(xin_valid), .in_ready(xin_ready),
        .a(xa), .b(xb), .cin(xcin), .out_valid(xout_valid), .out_ready(xout_ready),
        .sum(xsum), .cout(xcout), .busy(xbusy)
`ifdef CBSA_BYPASS_STATS_EN
        , .bypass_cnt(xbypass_cnt)
`endif
    );

    // Reference: plain (W+1)-bit addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    endfunction

    // Reference: nibbles whose propagate bits are all ones.
    function automatic int ref_byp(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p;
        int n;
        p = x ^ y;
        n = 0;
        for (int i = 0; i < N; i++) if (p[4*i +: 4] == 4'hF) n++;
        return n;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 16-bit instance with out_ready already high.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input string name);
        logic [W:0] exp;
        int lat;
        exp = ref_add(oa, ob, oc);
        a = oa; b = ob; cin = oc; in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_before: got %b want 1", name, in_ready);
        end
        step;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4*N) begin
            step;
            lat++;
        end
        total++;
        if (lat != N) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, N);
        end
        total++;
        if ({cout, sum} !== exp || busy !== 1'b1) begin
            bad++; $display("FAIL %s result: got %h busy=%b want %h busy=1",
                            name, {cout, sum}, busy, exp);
        end
`ifdef CBSA_BYPASS_STATS_EN
        total++;
        if (int'(bypass_cnt) != ref_byp(oa, ob)) begin
            bad++; $display("FAIL %s bypass_cnt: got %0d want %0d", name, bypass_cnt,
                            ref_byp(oa, ob));
        end
`endif
        step;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== exp) begin
            bad++; $display("FAIL %s handoff: out_valid=%b in_ready=%b res=%h want 0 1 %h",
                            name, out_valid, in_ready, {cout, sum}, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0) begin
            bad++; $display("FAIL reset16: rdy=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                            in_ready, out_valid, busy, sum, cout);
        end
        total++;
        if (xin_ready !== 1'b1 || xout_valid !== 1'b0 || xsum !== '0 || xcout !== 1'b0) begin
            bad++; $display("FAIL reset32: rdy=%b ov=%b sum=%h cout=%b want 1 0 0 0",
                            xin_ready, xout_valid, xsum, xcout);
        end
`ifdef CBSA_BYPASS_STATS_EN
        total++;
        if (bypass_cnt !== '0) begin
            bad++; $display("FAIL reset_bypass: got %0d want 0", bypass_cnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        run_op(16'h1234, 16'h4321, 1'b0, "basic");
    endtask

    task automatic test_bypass;
        run_op(16'hFFFF, 16'h0000, 1'b1, "bypass_all");
        run_op(16'hFFFF, 16'h0001, 1'b0, "bypass_three");
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_backpressure;
        logic ok;
        int w;
        out_ready = 1'b0;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
        step;
        a = W'($urandom); b = W'($urandom); cin = 1'b1;
        w = 0;
        while (out_valid !== 1'b1 && w < 4*N) begin
            step;
            w++;
        end
        total++;
        if (w != N) begin
            bad++; $display("FAIL bp_latency: got %0d want %0d", w, N);
        end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 17'h10000) begin
                ok = 1'b0;
                $display("FAIL bp_hold cycle %0d: ov=%b rdy=%b res=%h want 1 0 10000",
                         i, out_valid, in_ready, {cout, sum});
            end
            step;
        end
        total++;
        if (!ok) bad++;
        out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== 17'h10000) begin
            bad++; $display("FAIL bp_handoff: ov=%b rdy=%b res=%h want 0 1 10000",
                            out_valid, in_ready, {cout, sum});
        end
        step;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_no_capture: busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        logic seen;
        out_ready = 1'b1;
        a = W'($urandom) | 16'h0101; b = W'($urandom); cin = 1'b1; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0) begin
            bad++; $display("FAIL midrun_reset: rdy=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                            in_ready, out_valid, busy, sum, cout);
        end
        seen = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            step;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL midrun_no_result: got out_valid pulse want none");
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp_q[$];
        int         byp_q[$];
        logic [W:0] exp;
        int cyc, last_acc, accepts, results, byp;
        logic acc;
        cyc = 0; last_acc = -1; accepts = 0; results = 0;
        out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        while (results < 5 && cyc < 200) begin
            in_valid = (accepts < 5);
            acc = (in_ready === 1'b1) && in_valid;
            if (acc) begin
                exp_q.push_back(ref_add(a, b, cin));
                byp_q.push_back(ref_byp(a, b));
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != N + 2) begin
                        bad++; $display("FAIL b2b_spacing: got %0d want %0d",
                                        cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                byp = byp_q.pop_front();
                total++;
                if ({cout, sum} !== exp) begin
                    bad++; $display("FAIL b2b_result %0d: got %h want %h", results,
                                    {cout, sum}, exp);
                end
`ifdef CBSA_BYPASS_STATS_EN
                total++;
                if (int'(bypass_cnt) != byp) begin
                    bad++; $display("FAIL b2b_bypass %0d: got %0d want %0d", results,
                                    bypass_cnt, byp);
                end
`endif
                results++;
            end
            step;
            cyc++;
            if (acc) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        total++;
        if (results != 5) begin
            bad++; $display("FAIL b2b_count: got %0d results want 5", results);
        end
    endtask

    task automatic test_width32;
        int lat;
        xout_ready = 1'b1;
        xa = 32'hFFFFFFFF; xb = 32'h00000001; xcin = 1'b1; xin_valid = 1'b1;
        step;
        xin_valid = 1'b0;
        lat = 0;
        while (xout_valid !== 1'b1 && lat < 4*N2) begin
            step;
            lat++;
        end
        total++;
        if (lat != N2) begin
            bad++; $display("FAIL w32_latency: got %0d want %0d", lat, N2);
        end
        total++;
        if (xsum !== 32'h00000001 || xcout !== 1'b1) begin
            bad++; $display("FAIL w32_result: got %b_%h want 1_00000001", xcout, xsum);
        end
        step;
        total++;
        if (xout_valid !== 1'b0 || xin_ready !== 1'b1) begin
            bad++; $display("FAIL w32_handoff: ov=%b rdy=%b want 0 1", xout_valid, xin_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        xin_valid = 1'b0; xout_ready = 1'b0; xa = '0; xb = '0; xcin = 1'b0;
        test_reset;
        test_basic;
        test_bypass;
        test_random;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        test_width32;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
